bsr_chain: RTL
==============

// Module: bsr_chain
//
// PURPOSE
//   Parametrised boundary-scan data register: WIDTH cells chained between tdi and tdo, each
//   with a shift/capture stage and a separate update (hold) stage. Single clock with
//   capture/shift/update enables. Adds a safe-value drive mode and a defined reset state.
//   Sits between core-side logic and pins; the TAP controller drives the enables and mode.
//
// PARAMETERS
//   WIDTH       8        number of boundary cells (>=1)
//   RESET_VALUE '0       WIDTH-bit value loaded into shift and update stages on reset
//   SAFE_VALUE  '0       WIDTH-bit value driven on parallel_out in SAFE mode
//
// PORTS
//   clk           in   1      test clock; all state changes on rising edge
//   reset         in   1      asynchronous, active-high reset
//   capture_dr    in   1      load shift stage from parallel_in
//   shift_dr      in   1      shift chain one bit toward tdo
//   update_dr     in   1      copy shift stage into update stage
//   mode          in   2      0 TRANSPARENT, 1 DRIVE, 2 SAFE, 3 = DRIVE
//   tdi           in   1      serial input, enters cell WIDTH-1
//   parallel_in   in   WIDTH  system-side values (pins or core)
//   tdo           out  1      serial output = shift stage bit 0 (combinational)
//   parallel_out  out  WIDTH  value passed on to the other side of the boundary
//
// BEHAVIOUR
//   - Two WIDTH-bit registers: sreg (capture/shift) and ureg (update).
//   - reset asserted: sreg <= RESET_VALUE, ureg <= RESET_VALUE immediately; tdo =
//     RESET_VALUE[0]; parallel_out per mode (TRANSPARENT = parallel_in, DRIVE = RESET_VALUE,
//     SAFE = SAFE_VALUE). Reset mid-shift discards partially shifted data; no recovery.
//   - sreg per rising edge, priority capture_dr > shift_dr > hold:
//       capture_dr: sreg <= parallel_in
//       shift_dr:   sreg <= {tdi, sreg[WIDTH-1:1]}
//       neither:    sreg holds
//   - capture_dr & shift_dr both high is illegal for the TAP; RTL must still apply capture.
//   - ureg: update_dr high -> ureg <= sreg (value before this edge); else hold.
//   - update_dr concurrent with capture/shift: ureg takes pre-edge sreg; sreg updates
//     normally. No combinational path from tdi or parallel_in into ureg.
//   - Serial latency: bit written on tdi at shift edge n reaches tdo after WIDTH shift
//     edges; captured bit k appears on tdo after k shift edges. WIDTH=1: tdo=sreg[0].
//   - parallel_out combinational from mode: TRANSPARENT -> parallel_in; DRIVE/3 -> ureg;
//     SAFE -> SAFE_VALUE. Mode changes take effect without a clock edge.
//   - Outputs glitch-free w.r.t. clk: ureg changes only on update_dr edges, so
//     parallel_out in DRIVE mode is stable throughout capture/shift.
//   - No internal FSM; sequencing is the TAP's. Counter-free; chain length fixed by WIDTH.
//
// TESTING
//   1 Reset: RESET_VALUE=8'hA5, mode=1, assert reset mid-shift -> parallel_out=8'hA5
//     immediately, tdo=1, sreg/ureg=8'hA5 after release.
//   2 Capture+shift out: parallel_in=8'h3C, 1 capture, 8 shifts tdi=0 -> tdo LSB-first
//     0,0,1,1,1,1,0,0; sreg=8'h00 at end.
//   3 Shift in+update: shift 8'hC3 LSB-first on tdi, pulse update_dr, mode=1 ->
//     parallel_out=8'hC3; stays 8'hC3 across 20 further shift edges of other data.
//   4 Simultaneous: sreg=8'h0F, assert shift_dr and update_dr same edge tdi=1 ->
//     ureg=8'h0F, sreg=8'h87; capture_dr+shift_dr with parallel_in=8'h55 -> sreg=8'h55.
//   5 Modes: ureg=8'hF0, SAFE_VALUE=8'h00, parallel_in=8'h12: mode 0/1/2/3 ->
//     parallel_out 8'h12/8'hF0/8'h00/8'hF0, no clock required.
//   6 WIDTH=1 and WIDTH=33 builds: capture/shift/update round-trip random data matches model.

Source files
------------

// File: rtl/bsr_chain_if.sv
// bsr_chain_if: TAP-side control, serial and parallel boundary signals for one scan register
interface bsr_chain_if #(parameter int WIDTH = 8);
  logic             capture_dr;
  logic             shift_dr;
  logic             update_dr;
  logic [1:0]       mode;
  logic             tdi;
  logic [WIDTH-1:0] parallel_in;
  logic             tdo;
  logic [WIDTH-1:0] parallel_out;
  modport master (output capture_dr, shift_dr, update_dr, mode, tdi, parallel_in,
                  input  tdo, parallel_out);
  modport slave  (input  capture_dr, shift_dr, update_dr, mode, tdi, parallel_in,
                  output tdo, parallel_out);
endinterface

// File: rtl/bsr_chain.sv
// bsr_chain: boundary-scan data register with shift/capture and update stages plus safe drive mode
module bsr_chain #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] SAFE_VALUE  = '0
) (
  input logic        clk,
  input logic        reset,
  bsr_chain_if.slave bus
);
  logic [WIDTH-1:0] sreg_q, sreg_d, ureg_q, ureg_d, shifted;
  // Shift form that stays legal for WIDTH == 1 (tdi lands directly in bit 0).
  assign shifted = (WIDTH'(bus.tdi) << (WIDTH - 1)) | (sreg_q >> 1);
  always_comb begin
    sreg_d = bus.capture_dr ? bus.parallel_in : bus.shift_dr ? shifted : sreg_q;
    ureg_d = bus.update_dr ? sreg_q : ureg_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sreg_q <= RESET_VALUE;
      ureg_q <= RESET_VALUE;
    end else begin
      sreg_q <= sreg_d;
      ureg_q <= ureg_d;
    end
  assign bus.tdo = sreg_q[0];
  assign bus.parallel_out = bus.mode == 2'd0 ? bus.parallel_in :
                            bus.mode == 2'd2 ? SAFE_VALUE : ureg_q;
endmodule
